// File: rtl/bz_pkg.sv
// Types and helpers shared by the buzzer music player and the tone decoder.
// Record fields use the player's units: period and duration in clk cycles.
package bz_pkg;

    localparam int TUNE_W = 20;
    localparam int BEAT_W = 28;

    typedef struct packed {
        logic [TUNE_W-1:0] period;
        logic [BEAT_W-1:0] duration;
    } tone_rec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        TONE = 2'd2
    } dec_state_t;

    // True when p lies within l +/- (l >> shift); all arithmetic unsigned.
    function automatic logic period_match(
        input logic [TUNE_W-1:0] p,
        input logic [TUNE_W-1:0] l,
        input int unsigned       shift
    );
        logic [TUNE_W-1:0] diff;
        diff = (p >= l) ? (p - l) : (l - p);
        return (diff <= (l >> shift));
    endfunction

    // Duration plus one period, clamped at the top of the duration range.
    function automatic logic [BEAT_W-1:0] sat_add_beat(
        input logic [BEAT_W-1:0] a,
        input logic [TUNE_W-1:0] b
    );
        logic [BEAT_W:0] sum;
        sum = {1'b0, a} + {{(BEAT_W + 1 - TUNE_W){1'b0}}, b};
        return sum[BEAT_W] ? {BEAT_W{1'b1}} : sum[BEAT_W-1:0];
    endfunction

endpackage

// File: rtl/buzzer_tone_decoder_edge_period_meter.sv
// Synchronises the beep line, detects rising edges, rejects edges that come
// too soon after the previous accepted one, and counts cycles between edges.
module edge_period_meter
    import bz_pkg::*;
#(
    parameter int MIN_PERIOD = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              beep_in,
    output logic              edge_acc,
    output logic [TUNE_W-1:0] p
);

    localparam logic [TUNE_W-1:0] CNT_MAX = {TUNE_W{1'b1}};
    localparam logic [TUNE_W-1:0] MIN_P   = TUNE_W'(MIN_PERIOD);
    localparam logic [TUNE_W-1:0] CNT_ONE = TUNE_W'(1);

    // [0],[1] are the synchroniser flops, [2] holds the previous synced level.
    logic [2:0]        sync_reg;
    logic [TUNE_W-1:0] cnt_p_reg;
    logic              seen_reg;
    logic              rise;

    assign rise = sync_reg[1] & ~sync_reg[2];

    // Before the first accepted edge there is no reference, so nothing is gated.
    assign edge_acc = rise & (~seen_reg | (cnt_p_reg >= MIN_P));
    assign p        = cnt_p_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg  <= '0;
            cnt_p_reg <= '0;
            seen_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], beep_in};
            if (edge_acc) begin
                cnt_p_reg <= CNT_ONE;
                seen_reg  <= 1'b1;
            end else if (cnt_p_reg != CNT_MAX) begin
                cnt_p_reg <= cnt_p_reg + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/buzzer_tone_decoder.sv
// Turns a square-wave beep line back into {period,duration} note records,
// held in a single-entry output register with a valid/ready handshake.
module buzzer_tone_decoder
    import bz_pkg::*;
#(
    parameter int TOL_SHIFT    = 4,
    parameter int MIN_PERIOD   = 64,
    parameter int REST_TIMEOUT = 200000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              beep_in,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [TUNE_W-1:0] note_period,
    output logic [BEAT_W-1:0] note_duration,
    output logic              note_done,
    output logic              overflow
);

    localparam logic [TUNE_W-1:0] RT_LIM  = TUNE_W'(REST_TIMEOUT);
    localparam logic [BEAT_W-1:0] D_MAX   = {BEAT_W{1'b1}};
    localparam logic [BEAT_W-1:0] D_ONE   = BEAT_W'(1);

    logic              edge_acc;
    logic [TUNE_W-1:0] p;

    edge_period_meter #(
        .MIN_PERIOD (MIN_PERIOD)
    ) u_meter (
        .clk      (clk),
        .rstn     (rstn),
        .beep_in  (beep_in),
        .edge_acc (edge_acc),
        .p        (p)
    );

    dec_state_t        state_reg;
    logic [BEAT_W-1:0] cnt_d_reg;
    logic [BEAT_W-1:0] first_reg;
    logic [BEAT_W-1:0] last_reg;
    logic [TUNE_W-1:0] lock_reg;
    tone_rec_t         out_rec_reg;
    logic              note_valid_reg;
    logic              note_done_reg;
    logic              overflow_reg;

    logic              timeout;
    logic              match;
    logic              emit;
    tone_rec_t         emit_rec;
    logic [BEAT_W-1:0] span;

    assign timeout = (p > RT_LIM);
    assign match   = period_match(p, lock_reg, TOL_SHIFT);
    assign span    = last_reg - first_reg;

    // A mismatching edge closes the note at its last edge; a timeout also
    // credits the final period, which ran out after that last edge.
    always_comb begin
        emit     = 1'b0;
        emit_rec = '0;
        if (state_reg == TONE) begin
            if (edge_acc && !match) begin
                emit              = 1'b1;
                emit_rec.period   = lock_reg;
                emit_rec.duration = span;
            end else if (!edge_acc && timeout) begin
                emit              = 1'b1;
                emit_rec.period   = lock_reg;
                emit_rec.duration = sat_add_beat(span, lock_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            cnt_d_reg      <= '0;
            first_reg      <= '0;
            last_reg       <= '0;
            lock_reg       <= '0;
            out_rec_reg    <= '0;
            note_valid_reg <= 1'b0;
            note_done_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            note_done_reg <= 1'b0;
            if (cnt_d_reg != D_MAX) begin
                cnt_d_reg <= cnt_d_reg + D_ONE;
            end

            // cnt_d is the note's timebase; first/last are timestamps on it.
            case (state_reg)
                IDLE: begin
                    cnt_d_reg <= '0;
                    if (edge_acc) begin
                        first_reg <= '0;
                        last_reg  <= '0;
                        cnt_d_reg <= D_ONE;
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    if (edge_acc) begin
                        lock_reg  <= p;
                        last_reg  <= cnt_d_reg;
                        state_reg <= TONE;
                    end else if (timeout) begin
                        cnt_d_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
                TONE: begin
                    if (edge_acc) begin
                        last_reg <= cnt_d_reg;
                        if (!match) begin
                            first_reg <= last_reg;
                            lock_reg  <= p;
                        end
                    end else if (timeout) begin
                        cnt_d_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // A pending unaccepted record is never overwritten.
            if (emit) begin
                if (!note_valid_reg || note_ready) begin
                    out_rec_reg    <= emit_rec;
                    note_valid_reg <= 1'b1;
                    note_done_reg  <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (note_valid_reg && note_ready) begin
                note_valid_reg <= 1'b0;
            end
        end
    end

    assign note_valid    = note_valid_reg;
    assign note_period   = out_rec_reg.period;
    assign note_duration = out_rec_reg.duration;
    assign note_done     = note_done_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_buzzer_tone_decoder.sv
// Directed bench for buzzer_tone_decoder: tones, splits, jitter, glitches,
// back-pressure overflow and reset mid-tone.
module tb_buzzer_tone_decoder;
    import bz_pkg::*;

    localparam int RT = 1600;

    logic              clk;
    logic              rstn;
    logic              beep_in;
    logic              note_valid;
    logic              note_ready;
    logic [TUNE_W-1:0] note_period;
    logic [BEAT_W-1:0] note_duration;
    logic              note_done;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_base;
    logic [31:0] q_period[$];
    logic [31:0] q_dur[$];

    buzzer_tone_decoder #(
        .TOL_SHIFT    (4),
        .MIN_PERIOD   (64),
        .REST_TIMEOUT (RT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .beep_in       (beep_in),
        .note_valid    (note_valid),
        .note_ready    (note_ready),
        .note_period   (note_period),
        .note_duration (note_duration),
        .note_done     (note_done),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every accepted record and count load pulses.
    always @(posedge clk) begin
        if (rstn && note_valid && note_ready) begin
            q_period.push_back(32'(note_period));
            q_dur.push_back(32'(note_duration));
        end
        if (note_done) done_cnt = done_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int per);
        beep_in = 1'b1;
        cyc(per / 2);
        beep_in = 1'b0;
        cyc(per - per / 2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int idx, input logic [31:0] ep, input logic [31:0] ed);
        logic [31:0] op;
        logic [31:0] od;
        op = (q_period.size() > idx) ? q_period[idx] : 32'hFFFF_FFFF;
        od = (q_dur.size() > idx) ? q_dur[idx] : 32'hFFFF_FFFF;
        chk({tag, ".period"}, op, ep);
        chk({tag, ".duration"}, od, ed);
    endtask

    task automatic start_test();
        q_period.delete();
        q_dur.delete();
        done_base = done_cnt;
    endtask

    initial begin
        rstn       = 1'b0;
        beep_in    = 1'b0;
        note_ready = 1'b1;
        cyc(5);
        chk("rst.valid", 32'(note_valid), 0);
        chk("rst.done", 32'(note_done), 0);
        chk("rst.overflow", 32'(overflow), 0);
        chk("rst.period", 32'(note_period), 0);
        chk("rst.duration", 32'(note_duration), 0);
        rstn = 1'b1;
        cyc(100);

        // 20 periods of 1000 then silence: one record {1000,20000}.
        start_test();
        repeat (20) pulse(1000);
        cyc(RT + 100);
        chk("t1.count", 32'(q_period.size()), 1);
        chk_rec("t1.rec0", 0, 1000, 20000);
        chk("t1.done", 32'(done_cnt - done_base), 1);
        chk("t1.overflow", 32'(overflow), 0);
        $display("t1 steady tone: records=%0d", q_period.size());

        // 5 periods at 1000 then 5 at 1500: {1000,5000} then {1500,7500}.
        start_test();
        repeat (5) pulse(1000);
        repeat (5) pulse(1500);
        cyc(RT + 100);
        chk("t2.count", 32'(q_period.size()), 2);
        chk_rec("t2.rec0", 0, 1000, 5000);
        chk_rec("t2.rec1", 1, 1500, 7500);
        $display("t2 two notes: records=%0d", q_period.size());

        // Jitter inside the 6.25 % window stays one note.
        start_test();
        pulse(1000); pulse(1040); pulse(960);
        pulse(1000); pulse(1040); pulse(960); pulse(1000);
        cyc(RT + 100);
        chk("t3.count", 32'(q_period.size()), 1);
        chk_rec("t3.rec0", 0, 1000, 7000);
        $display("t3 jitter: records=%0d", q_period.size());

        // One 1100 spacing breaks the note and relocks at 1100.
        start_test();
        pulse(1000); pulse(1040);
        repeat (4) pulse(1100);
        cyc(RT + 100);
        chk("t4.count", 32'(q_period.size()), 2);
        chk_rec("t4.rec0", 0, 1000, 2040);
        chk_rec("t4.rec1", 1, 1100, 4400);
        $display("t4 split: records=%0d", q_period.size());

        // Single edge then silence: no record.
        start_test();
        pulse(1000);
        cyc(RT + 100);
        chk("t5.count", 32'(q_period.size()), 0);
        chk("t5.done", 32'(done_cnt - done_base), 0);
        $display("t5 lone edge: records=%0d", q_period.size());

        // Glitch edge 30 cycles after each real edge is ignored.
        start_test();
        repeat (3) begin
            beep_in = 1'b1; cyc(10);
            beep_in = 1'b0; cyc(20);
            beep_in = 1'b1; cyc(470);
            beep_in = 1'b0; cyc(500);
        end
        cyc(RT + 100);
        chk("t6.count", 32'(q_period.size()), 1);
        chk_rec("t6.rec0", 0, 1000, 3000);
        $display("t6 glitch: records=%0d", q_period.size());

        // Three notes with ready low: first held, later ones dropped.
        start_test();
        note_ready = 1'b0;
        repeat (4) pulse(300);
        repeat (3) pulse(600);
        repeat (2) pulse(1200);
        cyc(RT + 100);
        chk("t7.valid", 32'(note_valid), 1);
        chk("t7.period", 32'(note_period), 300);
        chk("t7.duration", 32'(note_duration), 1200);
        chk("t7.overflow", 32'(overflow), 1);
        chk("t7.done", 32'(done_cnt - done_base), 1);
        $display("t7 overflow: overflow=%0d", overflow);

        // Reset mid-tone clears everything and emits nothing afterwards.
        start_test();
        repeat (3) pulse(1000);
        beep_in = 1'b1;
        cyc(200);
        rstn = 1'b0;
        cyc(3);
        chk("t8.valid", 32'(note_valid), 0);
        chk("t8.period", 32'(note_period), 0);
        chk("t8.duration", 32'(note_duration), 0);
        chk("t8.done", 32'(note_done), 0);
        chk("t8.overflow", 32'(overflow), 0);
        beep_in = 1'b0;
        cyc(5);
        rstn = 1'b1;
        note_ready = 1'b1;
        done_base = done_cnt;
        cyc(RT + 200);
        chk("t8.post_done", 32'(done_cnt - done_base), 0);
        chk("t8.post_count", 32'(q_period.size()), 0);
        chk("t8.post_valid", 32'(note_valid), 0);
        $display("t8 reset mid-tone: records=%0d", q_period.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
